hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-003 SHALL have ports: ID_valid  in  1  ID holds a decoded instruction; ID_rs1_addr/ID_rs2_addr  in  5 each  source register numbers; ID_rs1_en/ID_rs2_en  in  1 each  source actually read.
REQ-004 SHALL have ports: ID_issue  in  1  ID-to-EXE handshake fires (ID_to_EXE_valid & EXE_allow_in); ID_dest  in  5; ID_rf_we  in  1; ID_is_load  in  1.
REQ-005 SHALL have ports: EXE_fire  in  1  EXE hands to MEM; MEM_fire  in  1  MEM hands to WB; WB_fire  in  1  WB retires (RF write).
REQ-006 SHALL have ports: ID_stall  out  1  ID_ready_go must be held low; fwd_sel1/fwd_sel2  out  2 each  source select (0 RegFile, 1 EXE, 2 MEM, 3 WB); stall_cnt  out  32  stall-cycle counter.

Function
REQ-007 SHALL hold three shadow slots EXE/MEM/WB, each {valid, dest[4:0], is_load}, mirroring in-flight register writers.
REQ-008 SHALL load EXE slot on ID_issue with valid = ID_rf_we & (ID_dest != 0).
REQ-009 SHALL move EXE->MEM on EXE_fire, MEM->WB on MEM_fire, clear WB slot on WB_fire unless refilled by MEM_fire same cycle.
REQ-010 SHALL process all fire signals of one cycle concurrently (shift semantics); slot not fired and not refilled holds.
REQ-011 SHALL clear EXE slot on EXE_fire without ID_issue in same cycle.
REQ-012 SHALL ignore ID_issue when EXE slot valid and EXE_fire low (protocol violation; slot keeps old content).
REQ-013 SHALL treat source n as hazardous only when ID_valid, ID_rsn_en, addr != 0, and matching a valid slot.
REQ-014 SHALL resolve multiple matches by youngest slot (EXE > MEM > WB).
REQ-015 SHALL drive ID_stall and fwd_sel combinationally from current slots and ID inputs (zero-cycle latency).
REQ-016 SHALL drive ID_stall = 0 and fwd_sel = 0 when ID_valid = 0.
REQ-017 SHALL increment stall_cnt by 1 each cycle ID_stall = 1, saturating at 32'hFFFF_FFFF.

Reset
REQ-018 SHALL, while reset = 0, force all slot valid bits 0, dest/is_load 0, stall_cnt 0; outputs ID_stall = 0, fwd_sel1 = fwd_sel2 = 0.
REQ-019 SHALL, on reset asserted mid-operation, discard in-flight slots without completing any shift; first edge after release samples normally.

Configuration
REQ-020 SHALL use macro HAZARD_FORWARD_EN.
REQ-021 SHALL with HAZARD_FORWARD_EN defined: stall only if youngest match is a load in EXE or MEM; otherwise fwd_sel = matching slot code (1/2/3), WB load forwardable.
REQ-022 SHALL without HAZARD_FORWARD_EN: stall on any match; fwd_sel1/fwd_sel2 tied 0.

Verification
REQ-023 SHALL cover: reset low with slots filled -> all outputs 0, stall_cnt 0 immediately.
REQ-024 SHALL cover: issue add dest r5, next cycle ID reads rs1=r5 (EXE slot) -> FWD_EN: stall 0, fwd_sel1 = 1; no FWD_EN: stall 1 until WB_fire clears r5, stall_cnt = 3 after 3 stalled cycles.
REQ-025 SHALL cover: ld dest r7 in EXE, ID rs2=r7 -> stall 1 (both configs); after EXE_fire stall 1 (MEM); after MEM_fire, FWD_EN: stall 0, fwd_sel2 = 3.
REQ-026 SHALL cover: r3 in EXE and MEM simultaneously, ID rs1=r3 -> fwd_sel1 = 1 (youngest).
REQ-027 SHALL cover: dest r0 issued, ID reads r0 -> no stall, fwd_sel = 0; rs1_en = 0 with matching addr -> no stall.
REQ-028 SHALL cover: ID_issue, EXE_fire, MEM_fire, WB_fire same cycle -> every slot shifts one position, WB old entry dropped, new entry in EXE.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage data-hazard detector for a five-stage pipeline.
// Keeps three shadow slots (EXE/MEM/WB) that mirror in-flight register
// writers, compares the ID stage's source registers against them, and
// produces a stall request and forwarding selects every cycle.
// Optional feature macro: HAZARD_FORWARD_EN
//   defined   -> forward from the youngest matching slot; stall only on a
//                load that is still in EXE or MEM
//   undefined -> stall on any match; forwarding selects are tied to 0
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_valid,
  input  logic [4:0]  ID_rs1_addr,
  input  logic [4:0]  ID_rs2_addr,
  input  logic        ID_rs1_en,
  input  logic        ID_rs2_en,
  input  logic        ID_issue,
  input  logic [4:0]  ID_dest,
  input  logic        ID_rf_we,
  input  logic        ID_is_load,
  input  logic        EXE_fire,
  input  logic        MEM_fire,
  input  logic        WB_fire,
  output logic        ID_stall,
  output logic [1:0]  fwd_sel1,
  output logic [1:0]  fwd_sel2,
  output logic [31:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } slot_t;

  slot_t       exe_q, exe_d;
  slot_t       mem_q, mem_d;
  slot_t       wb_q,  wb_d;
  logic [31:0] cnt_q, cnt_d;
  logic        exe_accept;

  // Per-source views so both read ports share one comparison structure.
  logic [4:0]  src_addr  [2];
  logic [1:0]  src_en;
  logic [1:0]  src_stall;
  logic [1:0]  src_sel   [2];

  assign src_addr[0] = ID_rs1_addr;
  assign src_addr[1] = ID_rs2_addr;
  assign src_en      = {ID_rs2_en, ID_rs1_en};

  // Slot next-state: all fire signals of a cycle act as one concurrent shift.
  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    // An issue into an occupied EXE slot that is not leaving is a protocol
    // violation; it is dropped so the real occupant is not lost.
    exe_accept = ID_issue & (~exe_q.valid | EXE_fire);

    if (MEM_fire)     wb_d = mem_q;
    else if (WB_fire) wb_d = '0;

    if (EXE_fire)      mem_d = exe_q;
    else if (MEM_fire) mem_d = '0;

    if (exe_accept) begin
      // Writes to r0 are architecturally invisible, so never track them.
      exe_d.valid   = ID_rf_we & (ID_dest != 5'd0);
      exe_d.dest    = ID_dest;
      exe_d.is_load = ID_is_load;
    end else if (EXE_fire) begin
      exe_d = '0;
    end
  end

  // Per-source hazard resolution, youngest matching slot wins.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic       live;
    logic       hit_exe, hit_mem, hit_wb;
    logic       stall_l;
    logic [1:0] sel_l;

    // Match this source against each slot and pick the youngest hit.
    always_comb begin
      live    = ID_valid & src_en[gi] & (src_addr[gi] != 5'd0);
      hit_exe = live & exe_q.valid & (exe_q.dest == src_addr[gi]);
      hit_mem = live & mem_q.valid & (mem_q.dest == src_addr[gi]);
      hit_wb  = live & wb_q.valid  & (wb_q.dest  == src_addr[gi]);
      stall_l = 1'b0;
      sel_l   = 2'd0;
`ifdef HAZARD_FORWARD_EN
      // Load data is not available before WB, so a load in EXE or MEM must
      // stall; everything else is bypassed from the stage that holds it.
      if (hit_exe) begin
        if (exe_q.is_load) stall_l = 1'b1;
        else               sel_l   = 2'd1;
      end else if (hit_mem) begin
        if (mem_q.is_load) stall_l = 1'b1;
        else               sel_l   = 2'd2;
      end else if (hit_wb) begin
        sel_l = 2'd3;
      end
`else
      stall_l = hit_exe | hit_mem | hit_wb;
`endif
    end

    assign src_stall[gi] = stall_l;
    assign src_sel[gi]   = sel_l;
  end

  assign ID_stall  = |src_stall;
  assign fwd_sel1  = src_sel[0];
  assign fwd_sel2  = src_sel[1];
  assign stall_cnt = cnt_q;

  // Stall-cycle counter, saturating so it never wraps back to a small value.
  always_comb begin
    cnt_d = cnt_q;
    if (ID_stall && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  // State registers; reset discards in-flight slots immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
